// File: rtl/mbist_pkg.sv
// mbist_pkg: FSM encoding, mode codes and march element op-tables
package mbist_pkg;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic MODE_MARCH_C = 1'b0;
    localparam logic MODE_MATS    = 1'b1;

    // Per-element tables indexed by March C- element number (0..5, padded to 8).
    // ELEM_TWO: element has two ops; ELEM_DOWN: addresses descend.
    localparam logic [7:0] ELEM_TWO  = 8'b0001_1110;
    localparam logic [7:0] ELEM_DOWN = 8'b0011_1000;
    // Per-op tables indexed by {element, op}: OP_WR = write, OP_INV = uses ~D.
    localparam logic [15:0] OP_WR  = 16'h02A9;
    localparam logic [15:0] OP_INV = 16'h0198;

    // MATS+ reuses March C- elements 0, 1 and 4 (r~D,wD descending).
    function automatic logic [2:0] tbl_idx(input logic mode, input logic [2:0] e);
        return (mode == MODE_MATS && e == 3'd2) ? 3'd4 : e;
    endfunction

    function automatic logic [2:0] last_elem(input logic mode);
        return (mode == MODE_MATS) ? 3'd2 : 3'd5;
    endfunction

endpackage

// File: rtl/mbist_fail_log.sv
// mbist_fail_log: one-cycle read pipeline, compare against memory data and failure logging
module mbist_fail_log #(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              rd,
    input  logic [DATA_W-1:0] exp,
    input  logic [ADDR_W-1:0] addr,
    input  logic [2:0]        elem,
    input  logic [DATA_W-1:0] dat_in,
    output logic              pass,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [2:0]        fail_elem,
    output logic [CNT_W-1:0]  fail_cnt
);

    logic              p_vld;
    logic [DATA_W-1:0] p_exp;
    logic [ADDR_W-1:0] p_addr;
    logic [2:0]        p_elem;
    logic              miss;

    assign miss = p_vld && dat_in != p_exp;

    // Hold the issued read for one cycle, then log it when its data mismatches
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_vld     <= 1'b0;
            p_exp     <= '0;
            p_addr    <= '0;
            p_elem    <= '0;
            pass      <= 1'b0;
            fail_addr <= '0;
            fail_elem <= '0;
            fail_cnt  <= '0;
        end else if (clr) begin
            p_vld     <= 1'b0;
            pass      <= 1'b1;
            fail_addr <= '0;
            fail_elem <= '0;
            fail_cnt  <= '0;
        end else begin
            p_vld  <= rd;
            p_exp  <= exp;
            p_addr <= addr;
            p_elem <= elem;
            if (miss) begin
                pass <= 1'b0;
                if (~&fail_cnt) fail_cnt <= fail_cnt + 1'b1;
                if (pass) begin
                    fail_addr <= p_addr;
                    fail_elem <= p_elem;
                end
            end
        end
    end

endmodule

// File: rtl/march_bist_ctrl.sv
// march_bist_ctrl: March C- / MATS+ memory BIST sequencer with registered memory port
module march_bist_ctrl
    import mbist_pkg::*;
#(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en_in,
    input  logic              mode_in,
    input  logic [DATA_W-1:0] bg_in,
    input  logic [DATA_W-1:0] dat_in,
    output logic [DATA_W-1:0] dat_out,
    output logic [ADDR_W-1:0] addr_out,
    output logic              w_en_out,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [2:0]        fail_elem,
    output logic [CNT_W-1:0]  fail_cnt
);

    logic [1:0]        state;
    logic              mode_q;
    logic [DATA_W-1:0] bg_q;
    logic [2:0]        elem, elem_bus, idx, nidx;
    logic              op, seq_end, rd_bus;
    logic [ADDR_W-1:0] addr;
    logic              op_last, addr_last, seq_last, start, rd_cmp;

    assign idx       = tbl_idx(mode_q, elem);
    assign nidx      = tbl_idx(mode_q, elem + 3'd1);
    assign op_last   = op == ELEM_TWO[idx];
    assign addr_last = ELEM_DOWN[idx] ? addr == '0 : &addr;
    assign seq_last  = op_last && addr_last && elem == last_elem(mode_q);
    assign busy      = state == S_RUN || state == S_DRAIN;
    assign done      = state == S_DONE;
    assign start     = state == S_IDLE && en_in;
    // A read on the port in an abort cycle is dropped before it reaches the compare.
    assign rd_cmp    = state == S_RUN && en_in && rd_bus;

    // Run FSM; the sequencer registers one op per RUN cycle onto the memory port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            mode_q   <= 1'b0;
            bg_q     <= '0;
            elem     <= '0;
            elem_bus <= '0;
            op       <= 1'b0;
            addr     <= '0;
            seq_end  <= 1'b0;
            rd_bus   <= 1'b0;
            addr_out <= '0;
            dat_out  <= '0;
            w_en_out <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (en_in) begin
                    state   <= S_RUN;
                    mode_q  <= mode_in;
                    bg_q    <= bg_in;
                    elem    <= '0;
                    op      <= 1'b0;
                    addr    <= '0;
                    seq_end <= 1'b0;
                end
                S_RUN: if (!en_in || seq_end) begin
                    state    <= en_in ? S_DRAIN : S_IDLE;
                    w_en_out <= 1'b0;
                    rd_bus   <= 1'b0;
                end else begin
                    addr_out <= addr;
                    dat_out  <= OP_INV[{idx, op}] ? ~bg_q : bg_q;
                    w_en_out <= OP_WR[{idx, op}];
                    rd_bus   <= !OP_WR[{idx, op}];
                    elem_bus <= elem;
                    seq_end  <= seq_last;
                    if (!op_last) op <= 1'b1;
                    else begin
                        op <= 1'b0;
                        if (!addr_last) addr <= ELEM_DOWN[idx] ? addr - 1'b1 : addr + 1'b1;
                        else begin
                            elem <= elem + 3'd1;
                            addr <= {ADDR_W{ELEM_DOWN[nidx]}};
                        end
                    end
                end
                S_DRAIN: state <= en_in ? S_DONE : S_IDLE;
                default: if (!en_in) state <= S_IDLE;
            endcase
        end
    end

    mbist_fail_log #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .CNT_W (CNT_W)
    ) u_fail_log (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (start),
        .rd       (rd_cmp),
        .exp      (dat_out),
        .addr     (addr_out),
        .elem     (elem_bus),
        .dat_in   (dat_in),
        .pass     (pass),
        .fail_addr(fail_addr),
        .fail_elem(fail_elem),
        .fail_cnt (fail_cnt)
    );

endmodule
